// File: rtl/mem_arbiter_if.sv
// Pipeline-side bus of the SRAM arbiter: IF fetch port, MEM load/store port and stall.
interface mem_arbiter_if;
  logic        if_req;
  logic [17:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall_o;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, stall_o
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stall_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one asynchronous SRAM between instruction fetch and
// the MEM stage; MEM wins, writes use a setup/pulse/hold sequence on Ram2WE.
module mem_arbiter #(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output logic [17:0] Ram2Addr,
  inout  wire  [15:0] Ram2Data,
  output logic        Ram2OE,
  output logic        Ram2WE,
  output logic        Ram2EN
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_ACK      = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_owner_mem;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_mem_rdata;
  logic            r_en;
  logic            r_oe;
  logic            r_we;
  logic            r_drive;
  logic            r_if_ack;
  logic            r_mem_ack;

  logic            w_grant;
  logic            w_last_rd;
  logic            w_en;
  logic            w_oe;
  logic            w_we;
  logic            w_drive;
  logic            w_if_ack;
  logic            w_mem_ack;

  // Arbitration happens from IDLE and directly from ACK, so back-to-back grants add no bubble.
  assign w_grant   = ((r_state == S_IDLE) || (r_state == S_ACK)) && (bus.mem_req || bus.if_req);
  assign w_last_rd = (r_state == S_READ) && (r_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ACK: begin
        if (bus.mem_req)     w_next = bus.mem_we ? S_WR_SETUP : S_READ;
        else if (bus.if_req) w_next = S_READ;
        else                 w_next = S_IDLE;
      end
      S_READ:     if (w_last_rd) w_next = S_ACK;
      S_WR_SETUP: w_next = S_WR_PULSE;
      S_WR_PULSE: w_next = S_WR_HOLD;
      S_WR_HOLD:  w_next = S_ACK;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so the pins are registered yet aligned with the state
  always_comb begin
    w_en      = 1'b1;
    w_oe      = 1'b1;
    w_we      = 1'b1;
    w_drive   = 1'b0;
    w_if_ack  = 1'b0;
    w_mem_ack = 1'b0;
    case (w_next)
      S_READ: begin
        w_en = 1'b0;
        w_oe = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        w_en    = 1'b0;
        w_drive = 1'b1;
      end
      S_WR_PULSE: begin
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_drive = 1'b1;
      end
      S_ACK: begin
        w_if_ack  = ~r_owner_mem;
        w_mem_ack = r_owner_mem;
      end
      default: ;
    endcase
  end

  // SRAM control pins and acks; reset releases WE/EN without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b1;
      r_oe      <= 1'b1;
      r_we      <= 1'b1;
      r_drive   <= 1'b0;
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
    end else begin
      r_en      <= w_en;
      r_oe      <= w_oe;
      r_we      <= w_we;
      r_drive   <= w_drive;
      r_if_ack  <= w_if_ack;
      r_mem_ack <= w_mem_ack;
    end
  end

  // Grant latch, read wait counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_mem <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner_mem <= bus.mem_req;
        r_addr      <= bus.mem_req ? bus.mem_addr : bus.if_addr;
        r_wdata     <= bus.mem_wdata;
        r_cnt       <= CW'(RD_WAIT - 1);
      end else if ((r_state == S_READ) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_last_rd) begin
        if (r_owner_mem) r_mem_rdata <= Ram2Data;
        else             r_if_rdata  <= Ram2Data;
      end
    end
  end

  assign Ram2Addr = r_addr;
  assign Ram2Data = r_drive ? r_wdata : {DW{1'bz}};
  assign Ram2OE   = r_oe;
  assign Ram2WE   = r_we;
  assign Ram2EN   = r_en;

  assign bus.if_ack    = r_if_ack;
  assign bus.mem_ack   = r_mem_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.stall_o   = (bus.if_req & ~r_if_ack) | (bus.mem_req & ~r_mem_ack);

endmodule
